// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: FIFO sizing, frame length
// and the common scan codes.
package ps2_pkg;

    localparam int FIFO_AW   = 3;
    localparam int FRAME_LEN = 11;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;

    // Odd parity holds when the payload plus parity bit has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_kbd_controller_if.sv
// Consumer-side port bundle of the keyboard receiver.
// Handshake: ready=1 means data holds the oldest byte; a high-to-low edge on
// nextdata_n consumes exactly that byte, and edges seen while ready=0 are ignored.
interface ps2_kbd_if;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    modport master (output nextdata_n, input data, input ready, input overflow);
    modport slave  (input nextdata_n, output data, output ready, output overflow);
endinterface

// File: rtl/ps2_edge_sync.sv
// Three-flop synchronizer for an asynchronous input with a one-clock strobe
// on each synchronized high-to-low transition.
module ps2_edge_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {3{RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_kbd_controller.sv
// PS/2 keyboard receiver: oversamples ps2_clk, deframes 11-bit frames and
// queues valid scan codes in a small FIFO popped by nextdata_n edges.
module ps2_kbd_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_AW = ps2_pkg::FIFO_AW
) (
    input  logic     clk,
    input  logic     clrn,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_kbd_if.slave host
);

    localparam logic [3:0] STOP_IDX = 4'(FRAME_LEN - 1);

    logic               sample_stb;
    logic               pop_stb;
    logic [3:0]         count_q, count_d;
    logic [9:0]         buf_q, buf_d;
    logic [FIFO_AW-1:0] w_ptr_q, w_ptr_d;
    logic [FIFO_AW-1:0] r_ptr_q, r_ptr_d;
    logic               ready_q, ready_d;
    logic               overflow_q, overflow_d;
    logic               frame_ok;
    logic               full;
    logic               push;
    logic               pop;
    logic [7:0]         fifo_mem [2**FIFO_AW];

    ps2_edge_sync #(.RST_VAL(1'b0)) u_clk_sync (
        .clk   (clk),
        .rst_n (clrn),
        .din   (ps2_clk),
        .fall  (sample_stb)
    );

    // Idle-high history so a consumer holding nextdata_n low at reset release
    // does not produce a spurious pop.
    ps2_edge_sync #(.RST_VAL(1'b1)) u_pop_sync (
        .clk   (clk),
        .rst_n (clrn),
        .din   (host.nextdata_n),
        .fall  (pop_stb)
    );

    always_comb begin
        count_d    = count_q;
        buf_d      = buf_q;
        frame_ok   = 1'b0;
        full       = ((w_ptr_q + FIFO_AW'(1)) == r_ptr_q);

        if (sample_stb) begin
            if (count_q == STOP_IDX) begin
                count_d  = 4'd0;
                frame_ok = !buf_q[0] && ps2_data && odd_parity_ok(buf_q[9:1]);
            end else begin
                buf_d[count_q] = ps2_data;
                count_d        = count_q + 4'd1;
            end
        end

        push       = frame_ok && !full;
        pop        = pop_stb && ready_q;
        w_ptr_d    = w_ptr_q + {{(FIFO_AW-1){1'b0}}, push};
        r_ptr_d    = r_ptr_q + {{(FIFO_AW-1){1'b0}}, pop};
        ready_d    = (w_ptr_d != r_ptr_d);
        overflow_d = overflow_q | (frame_ok & full);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_q    <= 4'd0;
            buf_q      <= 10'd0;
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            buf_q      <= buf_d;
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; ready gates whatever it holds.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[w_ptr_q] <= buf_q[8:1];
    end

    assign host.ready    = ready_q;
    assign host.overflow = overflow_q;
    assign host.data     = ready_q ? fifo_mem[r_ptr_q] : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_controller.sv
// Bench for ps2_kbd_controller: keyboard model, FIFO reference model and a
// pop monitor that checks every consumed byte against an expected queue.
module tb_ps2_kbd_controller;
    import ps2_pkg::*;

    localparam int CAP = 7;

    logic clk;
    logic clrn;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_if kbd_if ();

    ps2_kbd_controller dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .host     (kbd_if)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         exp_ovf  = 1'b0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] exp_data;
        exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check({tag, "_ready"},    32'(kbd_if.ready),    32'(model_q.size() != 0));
        check({tag, "_data"},     32'(kbd_if.data),     32'(exp_data));
        check({tag, "_overflow"}, 32'(kbd_if.overflow), 32'(exp_ovf));
    endtask

    task automatic apply_reset();
        clrn = 1'b0;
        #10;
        model_q.delete();
        exp_ovf = 1'b0;
        check_state("in_reset");
        #10;
        clrn = 1'b1;
        #20;
    endtask

    // ---------------- driver tasks ----------------
    // Drives up to nbits of one frame; stop bit may carry a coincident pop pulse.
    task automatic kbd_sendframe(input logic [7:0] code, input bit par_ok, input bit start_v,
                                 input bit stop_v, input bit pop_at_stop, input int nbits);
        logic [10:0] f;
        f = {stop_v, (~^code) ^ ~par_ok, code, start_v};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            ps2_clk  = 1'b0;
            if (i == 10 && pop_at_stop) kbd_if.nextdata_n = 1'b0;
            #20;
            kbd_if.nextdata_n = 1'b1;
            #10;
            ps2_clk = 1'b1;
            #30;
        end
        ps2_data = 1'b1;
    endtask

    function automatic void model_push(input logic [7:0] code);
        if (model_q.size() < CAP) model_q.push_back(code);
        else                      exp_ovf = 1'b1;
    endfunction

    task automatic kbd_sendcode(input logic [7:0] code);
        kbd_sendframe(code, 1'b1, 1'b0, 1'b1, 1'b0, 11);
        model_push(code);
    endtask

    task automatic pop_byte();
        if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
        kbd_if.nextdata_n = 1'b0;
        #20;
        kbd_if.nextdata_n = 1'b1;
        #60;
    endtask

    // Pop pulse aligned with the stop-bit clock edge so push and pop share a cycle.
    task automatic send_with_pop(input logic [7:0] code);
        bit was_full;
        was_full = (model_q.size() == CAP);
        if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
        kbd_sendframe(code, 1'b1, 1'b0, 1'b1, 1'b1, 11);
        if (was_full) exp_ovf = 1'b1;
        else          model_q.push_back(code);
        #20;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (prev && !kbd_if.nextdata_n) begin
                if (exp_q.size() == 0) begin
                    check("pop_empty_ready", 32'(kbd_if.ready), 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("pop_ready", 32'(kbd_if.ready), 32'd1);
                    check("pop_data",  32'(kbd_if.data),  32'(e));
                end
            end
            prev = kbd_if.nextdata_n;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clrn              = 1'b1;
        ps2_clk           = 1'b1;
        ps2_data          = 1'b1;
        kbd_if.nextdata_n = 1'b1;
        #10;
        apply_reset();
        #100;
        check_state("idle_after_reset");

        // make/break pair, single pop per pulse
        kbd_sendcode(KEY_A);
        kbd_sendcode(BREAK);
        check_state("two_queued");
        pop_byte();
        check_state("after_pop1");
        pop_byte();
        check_state("after_pop2");

        // ordered delivery
        kbd_sendcode(KEY_A);
        pop_byte();
        repeat (3) kbd_sendcode(KEY_S);
        kbd_sendcode(BREAK);
        kbd_sendcode(KEY_S);
        check_state("five_queued");
        repeat (5) pop_byte();
        check_state("drained");

        // overflow: eighth frame dropped, flag sticky across pops
        for (int i = 0; i < 8; i++) kbd_sendcode(8'($urandom_range(0, 255)));
        check_state("overflowed");
        repeat (7) pop_byte();
        check_state("overflow_drained");
        pop_byte();
        check_state("pop_on_empty");
        apply_reset();
        check_state("overflow_cleared");

        // malformed frames are discarded silently
        kbd_sendcode(EXT);
        kbd_sendframe(KEY_A, 1'b0, 1'b0, 1'b1, 1'b0, 11);
        check_state("bad_parity");
        kbd_sendframe(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0, 11);
        check_state("bad_stop");
        kbd_sendframe(KEY_A, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        check_state("bad_start");
        pop_byte();
        kbd_sendcode(KEY_S);
        check_state("good_after_bad");
        pop_byte();

        // push and pop in the same cycle
        kbd_sendcode(KEY_A);
        send_with_pop(KEY_S);
        check_state("push_pop_same");
        pop_byte();
        check_state("push_pop_drained");

        // reset in the middle of a frame
        kbd_sendcode(KEY_A);
        kbd_sendframe(KEY_S, 1'b1, 1'b0, 1'b1, 1'b0, 5);
        apply_reset();
        check_state("mid_frame_reset");
        kbd_sendcode(BREAK);
        check_state("after_mid_reset");
        pop_byte();

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            int op;
            logic [7:0] code;
            op   = $urandom_range(0, 9);
            code = 8'($urandom_range(0, 255));
            if (op <= 4) begin
                if ($urandom_range(0, 7) == 0)
                    kbd_sendframe(code, 1'b0, 1'b0, 1'b1, 1'b0, 11);
                else
                    kbd_sendcode(code);
            end else if (op <= 8) begin
                pop_byte();
            end else begin
                send_with_pop(code);
            end
            check_state("random");
        end
        while (model_q.size() != 0) pop_byte();
        check_state("final_drain");
        #100;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
